// File: rtl/pattern_filler.sv
// Framebuffer pattern generator: writes one frame of solid, striped or checkerboard
// pixels over a ready/valid-style write port, optionally repeating frame after frame.
module pattern_filler #(
  parameter int H_RES       = 160,
  parameter int V_RES       = 120,
  parameter int ADDR_WIDTH  = 15,
  parameter int PIXEL_WIDTH = 1,
  parameter int TILE_SHIFT  = 3
) (
  input  logic                   clk_25,
  input  logic                   reset,
  input  logic                   start,
  input  logic [1:0]             mode,
  input  logic [PIXEL_WIDTH-1:0] fg_color,
  input  logic [PIXEL_WIDTH-1:0] bg_color,
  input  logic                   continuous,
  input  logic                   abort,
  input  logic                   wr_ready,
  output logic                   we,
  output logic [ADDR_WIDTH-1:0]  write_addr,
  output logic [PIXEL_WIDTH-1:0] pixel,
  output logic                   busy,
  output logic                   done,
  output logic [7:0]             frame_count
);

  // Counters are widened so that bit TILE_SHIFT always exists.
  localparam int XW = ($clog2(H_RES) > TILE_SHIFT) ? $clog2(H_RES) : TILE_SHIFT + 1;
  localparam int YW = ($clog2(V_RES) > TILE_SHIFT) ? $clog2(V_RES) : TILE_SHIFT + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [XW-1:0]          x_q, x_d;
  logic [YW-1:0]          y_q, y_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [1:0]             mode_q, mode_d;
  logic [PIXEL_WIDTH-1:0] fg_q, fg_d;
  logic [PIXEL_WIDTH-1:0] bg_q, bg_d;
  logic [PIXEL_WIDTH-1:0] pixel_q, pixel_d;
  logic [7:0]             fc_q, fc_d;
  logic                   we_q, we_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   last_s;

  function automatic logic pat_bit(input logic [1:0] m, input logic xb, input logic yb);
    logic b;
    case (m)
      2'd0:    b = 1'b1;
      2'd1:    b = xb;
      2'd2:    b = yb;
      2'd3:    b = xb ^ yb;
      default: b = 1'b1;
    endcase
    return b;
  endfunction

  assign last_s = (x_q == XW'(H_RES - 1)) && (y_q == YW'(V_RES - 1));

  // Next-state, counter and output-register computation.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    addr_d  = addr_q;
    mode_d  = mode_q;
    fg_d    = fg_q;
    bg_d    = bg_q;
    fc_d    = fc_q;
    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          state_d = ST_FILL;
          x_d     = '0;
          y_d     = '0;
          addr_d  = '0;
          mode_d  = mode;
          fg_d    = fg_color;
          bg_d    = bg_color;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FILL: begin
        if (abort) begin
          state_d = ST_IDLE;
          x_d     = '0;
          y_d     = '0;
          addr_d  = '0;
        end else if (we_q && wr_ready) begin
          if (last_s) begin
            state_d = ST_DONE;
            x_d     = '0;
            y_d     = '0;
            addr_d  = '0;
          end else begin
            addr_d = addr_q + ADDR_WIDTH'(1);
            if (x_q == XW'(H_RES - 1)) begin
              x_d = '0;
              y_d = y_q + YW'(1);
            end else begin
              x_d = x_q + XW'(1);
            end
          end
        end else begin
          state_d = ST_FILL;
        end
      end
      ST_DONE: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          fc_d = fc_q + 8'd1;
          if (continuous) begin
            state_d = ST_FILL;
            x_d     = '0;
            y_d     = '0;
            addr_d  = '0;
            mode_d  = mode;
            fg_d    = fg_color;
            bg_d    = bg_color;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        x_d     = '0;
        y_d     = '0;
        addr_d  = '0;
      end
    endcase

    // Pixel is computed from the next coordinates so it lands in the same cycle as its address.
    if (state_d == ST_FILL) begin
      pixel_d = pat_bit(mode_d, x_d[TILE_SHIFT], y_d[TILE_SHIFT]) ? fg_d : bg_d;
    end else begin
      pixel_d = '0;
    end
    we_d   = (state_d == ST_FILL);
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk_25 or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      addr_q  <= '0;
      mode_q  <= 2'd0;
      fg_q    <= '0;
      bg_q    <= '0;
      pixel_q <= '0;
      fc_q    <= 8'd0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      addr_q  <= addr_d;
      mode_q  <= mode_d;
      fg_q    <= fg_d;
      bg_q    <= bg_d;
      pixel_q <= pixel_d;
      fc_q    <= fc_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign we          = we_q;
  assign write_addr  = addr_q;
  assign pixel       = pixel_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign frame_count = fc_q;

endmodule

// File: tb/tb_pattern_filler.sv
// Directed self-checking bench for pattern_filler on a 4x3 frame with 2-pixel tiles.
module tb_pattern_filler;

  logic       clk_25 = 1'b0;
  logic       reset;
  logic       start;
  logic [1:0] mode;
  logic [0:0] fg_color;
  logic [0:0] bg_color;
  logic       continuous;
  logic       abort;
  logic       wr_ready;
  logic       we;
  logic [3:0] write_addr;
  logic [0:0] pixel;
  logic       busy;
  logic       done;
  logic [7:0] frame_count;

  int n_total = 0;
  int n_bad   = 0;
  int n_done  = 0;

  pattern_filler #(
    .H_RES(4), .V_RES(3), .ADDR_WIDTH(4), .PIXEL_WIDTH(1), .TILE_SHIFT(1)
  ) dut (
    .clk_25(clk_25), .reset(reset), .start(start), .mode(mode),
    .fg_color(fg_color), .bg_color(bg_color), .continuous(continuous),
    .abort(abort), .wr_ready(wr_ready), .we(we), .write_addr(write_addr),
    .pixel(pixel), .busy(busy), .done(done), .frame_count(frame_count)
  );

  always #20 clk_25 = ~clk_25;

  always @(negedge clk_25) begin
    if (done === 1'b1) n_done <= n_done + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Runs one frame from the negedge after start (or after DONE when continuous).
  task automatic fill_frame(input logic [11:0] exp_pix, input bit alt,
                            input logic [1:0] nm, input logic nf, input logic nb,
                            input logic nc);
    int idx = 0;
    int cyc = 0;
    bit rdy;
    while (idx < 12 && cyc < 100) begin
      @(negedge clk_25);
      cyc++;
      if (cyc == 1) begin
        start      = 1'b0;
        mode       = nm;
        fg_color   = nf;
        bg_color   = nb;
        continuous = nc;
      end
      if (we === 1'b1) begin
        chk("addr", 32'(write_addr), 32'(idx));
        chk("pixel", 32'(pixel), 32'(exp_pix[idx]));
        chk("busy_fill", 32'(busy), 32'd1);
        rdy      = alt ? cyc[0] : 1'b1;
        wr_ready = rdy;
        if (rdy) idx++;
      end else begin
        chk("we_fill", 32'(we), 32'd1);
      end
    end
    chk("xfers", 32'(idx), 32'd12);
    @(negedge clk_25);
    wr_ready = 1'b1;
    chk("done_pulse", 32'(done), 32'd1);
    chk("we_done", 32'(we), 32'd0);
  endtask

  task automatic idle_after(input logic [7:0] fc);
    @(negedge clk_25);
    chk("busy_after", 32'(busy), 32'd0);
    chk("done_after", 32'(done), 32'd0);
    chk("fc_after", 32'(frame_count), 32'(fc));
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; mode = 2'd0; fg_color = 1'b0; bg_color = 1'b0;
    continuous = 1'b0; abort = 1'b0; wr_ready = 1'b1;

    // Reset state and idle hold
    @(negedge clk_25);
    chk("rst_we", 32'(we), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_addr", 32'(write_addr), 32'd0);
    chk("rst_pixel", 32'(pixel), 32'd0);
    chk("rst_fc", 32'(frame_count), 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge clk_25);
    chk("idle_hold", 32'(busy), 32'd0);

    // Solid, always ready
    mode = 2'd0; fg_color = 1'b1; bg_color = 1'b0; start = 1'b1;
    fill_frame(12'hFFF, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
    idle_after(8'd1);

    // Checkerboard under alternating backpressure
    mode = 2'd3; fg_color = 1'b1; bg_color = 1'b0; start = 1'b1;
    fill_frame(12'h3CC, 1'b1, 2'd3, 1'b1, 1'b0, 1'b0);
    idle_after(8'd2);

    // Horizontal stripes, inputs scrambled mid-frame must not matter
    mode = 2'd2; fg_color = 1'b0; bg_color = 1'b1; start = 1'b1;
    fill_frame(12'h0FF, 1'b0, 2'd3, 1'b1, 1'b0, 1'b0);
    idle_after(8'd3);

    // Abort together with the transfer of address 5
    mode = 2'd0; fg_color = 1'b1; bg_color = 1'b0; start = 1'b1; wr_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_25);
      start = 1'b0;
      chk("ab_we", 32'(we), 32'd1);
      chk("ab_addr", 32'(write_addr), 32'(i));
      if (i == 5) abort = 1'b1;
    end
    @(negedge clk_25);
    abort = 1'b0;
    chk("ab_we_off", 32'(we), 32'd0);
    chk("ab_busy", 32'(busy), 32'd0);
    chk("ab_done", 32'(done), 32'd0);
    chk("ab_fc", 32'(frame_count), 32'd3);
    @(negedge clk_25);
    chk("ab_done2", 32'(done), 32'd0);
    start = 1'b1;
    fill_frame(12'hFFF, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
    idle_after(8'd4);

    // Asynchronous reset in the middle of a fill
    mode = 2'd0; start = 1'b1;
    repeat (3) @(negedge clk_25);
    start = 1'b0;
    chk("pre_rst_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    chk("mid_rst_we", 32'(we), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_addr", 32'(write_addr), 32'd0);
    chk("mid_rst_fc", 32'(frame_count), 32'd0);
    @(negedge clk_25);
    reset = 1'b0;
    @(negedge clk_25);
    chk("post_rst_idle", 32'(busy), 32'd0);

    // Continuous: frame 1 solid, mode switched to vertical stripes during it
    n_done = 0;
    mode = 2'd0; fg_color = 1'b1; bg_color = 1'b0; continuous = 1'b1; start = 1'b1;
    fill_frame(12'hFFF, 1'b0, 2'd1, 1'b1, 1'b0, 1'b1);
    fill_frame(12'hCCC, 1'b0, 2'd1, 1'b1, 1'b0, 1'b0);
    idle_after(8'd2);
    chk("cont_done_cnt", 32'(n_done), 32'd2);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/pattern_filler.md
PATTERN_FILLER -- requirements
Module: pattern_filler

Interface
REQ-001 SHALL provide parameter H_RES, default 160, horizontal pixels per line.
REQ-002 SHALL provide parameter V_RES, default 120, lines per frame.
REQ-003 SHALL provide parameter ADDR_WIDTH, default 15, framebuffer address width; H_RES*V_RES <= 2^ADDR_WIDTH.
REQ-004 SHALL provide parameter PIXEL_WIDTH, default 1, bits per pixel.
REQ-005 SHALL provide parameter TILE_SHIFT, default 3, log2 of stripe/tile size in pixels.
REQ-006 SHALL have port clk_25  in  1  sole clock; all state updates on its rising edge.
REQ-007 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-008 SHALL have port start  in  1  request to begin a fill, sampled in IDLE only.
REQ-009 SHALL have port mode  in  2  pattern: 0 solid, 1 vertical stripes, 2 horizontal stripes, 3 checkerboard.
REQ-010 SHALL have port fg_color  in  PIXEL_WIDTH  foreground value.
REQ-011 SHALL have port bg_color  in  PIXEL_WIDTH  background value.
REQ-012 SHALL have port continuous  in  1  restart a new frame automatically after each completed frame.
REQ-013 SHALL have port abort  in  1  terminate current fill.
REQ-014 SHALL have port wr_ready  in  1  framebuffer accepts the presented write this cycle.
REQ-015 SHALL have port we  out  1  write valid.
REQ-016 SHALL have port write_addr  out  ADDR_WIDTH  linear framebuffer address y*H_RES+x.
REQ-017 SHALL have port pixel  out  PIXEL_WIDTH  pixel data for write_addr.
REQ-018 SHALL have port busy  out  1  high whenever state is not IDLE.
REQ-019 SHALL have port done  out  1  one-cycle pulse per completed frame.
REQ-020 SHALL have port frame_count  out  8  completed frames, wraps 255->0.

Function
REQ-021 SHALL implement states IDLE, FILL, DONE.
REQ-022 IDLE: start=1 and abort=0 -> FILL next cycle with x=0, y=0, write_addr=0, we=1; mode, fg_color, bg_color latched at that edge.
REQ-023 Transfer occurs on a rising edge where we=1 and wr_ready=1; write_addr, pixel, we SHALL remain stable while we=1 and wr_ready=0.
REQ-024 On transfer, x increments; at x=H_RES-1, x wraps to 0 and y increments; write_addr increments by 1 (counter, no multiplier).
REQ-025 Transfer at x=H_RES-1, y=V_RES-1 -> DONE next cycle with we=0.
REQ-026 DONE lasts exactly one cycle: done=1, frame_count increments at exit edge; then FILL at address 0 with re-latched mode/colors if continuous=1, else IDLE.
REQ-027 pixel SHALL equal fg_color when pattern bit is 1, else bg_color; pattern bit: solid 1; vertical x[TILE_SHIFT]; horizontal y[TILE_SHIFT]; checkerboard x[TILE_SHIFT]^y[TILE_SHIFT].
REQ-028 pixel SHALL be valid combinationally with write_addr in the same cycle (zero latency between address and data).
REQ-029 abort=1 in FILL or DONE -> IDLE next cycle, we=0, no done pulse, frame_count unchanged; a write handshaking at that same edge counts as accepted by the sink.
REQ-030 abort has priority over start in IDLE and over continuous restart in DONE.
REQ-031 start while busy=1 SHALL be ignored; input changes to mode/colors while busy SHALL not affect the current frame.

Reset
REQ-032 reset=1 SHALL immediately force IDLE, x=y=0, write_addr=0, we=0, pixel=0, busy=0, done=0, frame_count=0, regardless of clock, including mid-frame.
REQ-033 After reset deassertion, block SHALL remain IDLE until start is sampled.

Verification (H_RES=4, V_RES=3, ADDR_WIDTH=4, TILE_SHIFT=1, PIXEL_WIDTH=1)
REQ-034 Reset: assert reset mid-FILL between edges -> we, busy, done, write_addr, frame_count all 0 before next edge.
REQ-035 Solid, wr_ready=1: start pulse, fg=1 -> 12 consecutive we cycles addr 0..11, pixel=1, done pulse next cycle, frame_count=1, busy=0 after.
REQ-036 Backpressure: wr_ready alternating 1/0 -> addr/pixel held on stalled cycles, exactly 12 transfers, addresses 0..11 each once.
REQ-037 Checkerboard fg=1 bg=0 -> pixel per addr 0..11 = 0,0,1,1, 0,0,1,1, 1,1,0,0.
REQ-038 Abort after transfer of addr 5 -> we=0 next cycle, no done, frame_count unchanged; subsequent start begins at addr 0.
REQ-039 continuous=1, mode changed to 1 during frame 1 -> frame 2 starts one cycle after done with vertical stripes, two done pulses, frame_count=2.
